// File: rtl/ml_dot_mmio_slave.sv
// ml_dot_mmio_slave: CPU load/store window holding A/B operand buffers and a signed dot-product engine.
// Latency: loads are combinational; with START stored at edge t, DONE and done_pulse follow edge t+LEN.
// Backpressure: none; stores are always taken, pushes to a full buffer or during a run drop data and set ERR.
// Build option: define ML_DOT_SAT_EN to saturate the accumulator on signed overflow instead of wrapping.
module ml_dot_mmio_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int          DEPTH     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        done_pulse
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_STATUS = 3'd1;
   localparam logic [2:0] OFF_LEN    = 3'd2;
   localparam logic [2:0] OFF_A      = 3'd3;
   localparam logic [2:0] OFF_B      = 3'd4;
   localparam logic [2:0] OFF_RESULT = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   typedef struct packed {
      logic [7:0] rsvd_hi;
      logic [7:0] b_cnt;
      logic [7:0] a_cnt;
      logic [3:0] rsvd_lo;
      logic       ovf;
      logic       err;
      logic       done;
      logic       busy;
   } status_t;

   state_t             state, state_nxt;
   logic [8:0]         a_cnt, b_cnt;
   logic [7:0]         len, idx;
   logic signed [31:0] acc;
   logic               err, ovf;
   logic [15:0]        a_mem [DEPTH];
   logic [15:0]        b_mem [DEPTH];

   logic               hit, wr_hit, busy;
   logic [2:0]         offset;
   logic               start, clear, len_wr, a_push, b_push;
   logic               a_push_ok, b_push_ok, start_bad, last_mac;
   logic [31:0]        a_ext, b_ext, prod;
   logic [32:0]        sum;
   logic               mac_ovf;
   logic [31:0]        acc_nxt;
   status_t            status;

   // Address bits below the word offset and the upper store bits carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{addr[1:0], write_data[31:16]};

   assign hit       = (addr[31:5] == BASE_ADDR[31:5]);
   assign offset    = addr[4:2];
   assign wr_hit    = mem_write && hit;
   assign busy      = (state == S_RUN);
   assign start     = wr_hit && (offset == OFF_CTRL) && write_data[0];
   assign clear     = wr_hit && (offset == OFF_CTRL) && write_data[1];
   assign len_wr    = wr_hit && (offset == OFF_LEN);
   assign a_push    = wr_hit && (offset == OFF_A);
   assign b_push    = wr_hit && (offset == OFF_B);
   assign a_push_ok = a_push && !busy && (a_cnt != 9'(DEPTH));
   assign b_push_ok = b_push && !busy && (b_cnt != 9'(DEPTH));
   assign start_bad = (len == 8'd0) || ({1'b0, len} > a_cnt) || ({1'b0, len} > b_cnt);
   assign last_mac  = busy && (idx == len - 8'd1);

   // One MAC step: sign-extended 16x16 product added to the accumulator with overflow detect.
   always_comb begin
      a_ext   = {{16{a_mem[idx[AW-1:0]][15]}}, a_mem[idx[AW-1:0]]};
      b_ext   = {{16{b_mem[idx[AW-1:0]][15]}}, b_mem[idx[AW-1:0]]};
      prod    = a_ext * b_ext;
      sum     = {acc[31], acc} + {prod[31], prod};
      mac_ovf = (sum[32] != sum[31]);
`ifdef ML_DOT_SAT_EN
      acc_nxt = mac_ovf ? (sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum[31:0];
`else
      acc_nxt = sum[31:0];
`endif
   end

   // Next-state logic; CLEAR overrides everything, START is only honoured outside a run.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start && !start_bad) state_nxt = S_RUN;
         S_RUN:          if (idx == len - 8'd1)   state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
      if (clear) state_nxt = S_IDLE;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Counters, LEN, accumulator, sticky flags and the completion pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_cnt      <= '0;
         b_cnt      <= '0;
         len        <= '0;
         idx        <= '0;
         acc        <= '0;
         err        <= 1'b0;
         ovf        <= 1'b0;
         done_pulse <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         if (clear) begin
            a_cnt <= '0;
            b_cnt <= '0;
            idx   <= '0;
            acc   <= '0;
            err   <= 1'b0;
            ovf   <= 1'b0;
         end else begin
            if (a_push) begin
               if (a_push_ok) a_cnt <= a_cnt + 9'd1;
               else           err   <= 1'b1;
            end
            if (b_push) begin
               if (b_push_ok) b_cnt <= b_cnt + 9'd1;
               else           err   <= 1'b1;
            end
            if (len_wr && !busy) len <= write_data[7:0];
            if (start && !busy) begin
               if (start_bad) begin
                  err <= 1'b1;
               end else begin
                  acc <= '0;
                  idx <= '0;
               end
            end
            if (busy) begin
               acc        <= acc_nxt;
               idx        <= idx + 8'd1;
               done_pulse <= last_mac;
               if (mac_ovf) ovf <= 1'b1;
            end
         end
      end
   end

   // Operand storage; contents survive reset and CLEAR, only the counts are cleared.
   always_ff @(posedge clk) begin
      if (!rst && a_push_ok) a_mem[a_cnt[AW-1:0]] <= write_data[15:0];
      if (!rst && b_push_ok) b_mem[b_cnt[AW-1:0]] <= write_data[15:0];
   end

   // Combinational load mux; loads observe the state before the current edge.
   always_comb begin
      status         = '0;
      status.busy    = busy;
      status.done    = (state == S_DONE);
      status.err     = err;
      status.ovf     = ovf;
      status.a_cnt   = a_cnt[7:0];
      status.b_cnt   = b_cnt[7:0];
      read_data      = '0;
      if (mem_read && hit) begin
         case (offset)
            OFF_STATUS: read_data = status;
            OFF_LEN:    read_data = {24'd0, len};
            OFF_RESULT: read_data = acc;
            default:    read_data = '0;
         endcase
      end
   end
endmodule
